// File: rtl/mips_hazard_pkg.sv
// Shared types and helpers for the ID-stage branch hazard logic.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mips_hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } br_state_t;

    // Register $0 is hardwired to zero, so a write to it never creates a hazard.
    localparam int ZERO_REG = 0;

    // Number of cycles the branch must wait before both comparator operands
    // are available. A load in EX needs two cycles; an ALU result in EX or a
    // load in MEM needs one. The largest requirement across rs/rt wins.
    function automatic logic [1:0] hazard_need(
        input logic match_e,
        input logic regwrite_e,
        input logic memtoreg_e,
        input logic match_m,
        input logic memtoreg_m
    );
        if (match_e && memtoreg_e) begin
            return 2'd2;
        end else if ((match_e && regwrite_e) || (match_m && memtoreg_m)) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst_n (sync, active-low), inc (count this cycle), count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolver: stalls until beq/bne operands are valid, then decides taken.
// Latency: pcsrc_d 0/1/2 cycles after the branch enters ID for hazard need 0/1/2.
// Backpressure: asserts stall_f/stall_d/flush_e for exactly need cycles per branch.
//
// Ports: branch_d/bne_d/rs_d/rt_d describe the ID branch; *_e/*_m describe the
// EX and MEM writers; eq_d is the comparator result. Outputs are comparator
// forwarding selects, front-end stall/flush, pcsrc_d/flush_d, and two
// saturating performance counters (stall cycles, taken branches).
module branch_resolve_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_d,
    input  logic             bne_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             regwrite_e,
    input  logic             memtoreg_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic             regwrite_m,
    input  logic             memtoreg_m,
    input  logic [REG_W-1:0] writereg_m,
    input  logic             eq_d,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             pcsrc_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    br_state_t  state, state_nxt, cur_state;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] need;
    logic       match_e, match_m;
    logic       stall;

    assign match_e = (writereg_e != ZERO_IDX) &&
                     ((writereg_e == rs_d) || (writereg_e == rt_d));
    assign match_m = (writereg_m != ZERO_IDX) &&
                     ((writereg_m == rs_d) || (writereg_m == rt_d));

    assign need = hazard_need(match_e, regwrite_e, memtoreg_e, match_m, memtoreg_m);

    // Only a MEM ALU result can be forwarded to the ID comparator; a MEM load
    // is still in flight and is covered by a stall instead.
    assign fwd_a_d = regwrite_m && !memtoreg_m && (writereg_m != ZERO_IDX) &&
                     (writereg_m == rs_d);
    assign fwd_b_d = regwrite_m && !memtoreg_m && (writereg_m != ZERO_IDX) &&
                     (writereg_m == rt_d);

    // While reset is held the outputs behave as in IDLE, even though the
    // state register only clears on the next edge.
    assign cur_state = rst_n ? state : IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = cur_state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        pcsrc_d   = 1'b0;
        case (cur_state)
            IDLE: begin
                if (branch_d) begin
                    case (need)
                        2'd0: pcsrc_d = eq_d ^ bne_d;
                        2'd1: begin
                            stall     = 1'b1;
                            state_nxt = RESOLVE;
                        end
                        default: begin
                            stall     = 1'b1;
                            cnt_nxt   = 2'd1;
                            state_nxt = STALL;
                        end
                    endcase
                end
            end
            STALL: begin
                if (!branch_d) begin
                    cnt_nxt   = 2'd0;
                    state_nxt = IDLE;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                    // Leave once this cycle's decrement reaches zero so the
                    // total stall count equals the need, not need+1.
                    if (cnt <= 2'd1) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                // Operands are valid by construction here; no hazard re-check.
                if (branch_d) begin
                    pcsrc_d = eq_d ^ bne_d;
                end
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = 2'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;
    assign flush_d = pcsrc_d;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pcsrc_d),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a cycle scoreboard.
// Latency: expectations are queued per cycle and checked on the falling edge.
// Backpressure: n/a.
module tb_branch_resolve_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             branch_d, bne_d;
    logic [REG_W-1:0] rs_d, rt_d;
    logic             regwrite_e, memtoreg_e;
    logic [REG_W-1:0] writereg_e;
    logic             regwrite_m, memtoreg_m;
    logic [REG_W-1:0] writereg_m;
    logic             eq_d;
    logic             fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, pcsrc_d, flush_d;
    logic [CNT_W-1:0] stall_cnt, taken_cnt;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .branch_d   (branch_d),
        .bne_d      (bne_d),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .regwrite_e (regwrite_e),
        .memtoreg_e (memtoreg_e),
        .writereg_e (writereg_e),
        .regwrite_m (regwrite_m),
        .memtoreg_m (memtoreg_m),
        .writereg_m (writereg_m),
        .eq_d       (eq_d),
        .fwd_a_d    (fwd_a_d),
        .fwd_b_d    (fwd_b_d),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_e    (flush_e),
        .pcsrc_d    (pcsrc_d),
        .flush_d    (flush_d),
        .stall_cnt  (stall_cnt),
        .taken_cnt  (taken_cnt)
    );

    typedef struct {
        string            tag;
        bit               chk_ctl;
        logic             stall;
        logic             fwd_a;
        logic             fwd_b;
        logic             pcsrc;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] tc;
    } exp_t;

    exp_t             sb[$];
    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] m_sc, m_tc;

    task automatic cmp(input string tag, input string what,
                       input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp_v);
        end
    endtask

    // One cycle: queue the expectation, check at negedge, then advance the
    // counter model across the rising edge.
    task automatic step(input string tag, input bit chk, input logic e_stall,
                        input logic e_fa, input logic e_fb, input logic e_pc);
        exp_t e;
        e.tag = tag; e.chk_ctl = chk; e.stall = e_stall;
        e.fwd_a = e_fa; e.fwd_b = e_fb; e.pcsrc = e_pc;
        e.sc = m_sc; e.tc = m_tc;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        cmp(e.tag, "pcsrc_d", 16'(pcsrc_d), 16'(e.pcsrc));
        cmp(e.tag, "fwd_a_d", 16'(fwd_a_d), 16'(e.fwd_a));
        cmp(e.tag, "fwd_b_d", 16'(fwd_b_d), 16'(e.fwd_b));
        if (e.chk_ctl) begin
            cmp(e.tag, "stall_f", 16'(stall_f), 16'(e.stall));
            cmp(e.tag, "stall_d", 16'(stall_d), 16'(e.stall));
            cmp(e.tag, "flush_e", 16'(flush_e), 16'(e.stall));
            cmp(e.tag, "flush_d", 16'(flush_d), 16'(e.pcsrc));
            cmp(e.tag, "stall_cnt", 16'(stall_cnt), 16'(e.sc));
            cmp(e.tag, "taken_cnt", 16'(taken_cnt), 16'(e.tc));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_sc = '0;
            m_tc = '0;
        end else begin
            if (e_stall && m_sc != CMAX) m_sc = m_sc + 1'b1;
            if (e_pc && m_tc != CMAX) m_tc = m_tc + 1'b1;
        end
        #1;
    endtask

    task automatic clear_in();
        branch_d = 0; bne_d = 0; rs_d = '0; rt_d = '0; eq_d = 0;
        regwrite_e = 0; memtoreg_e = 0; writereg_e = '0;
        regwrite_m = 0; memtoreg_m = 0; writereg_m = '0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        clear_in();
        step(tag, 1, 0, 0, 0, 0);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        clear_in();
        m_sc = '0;
        m_tc = '0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // No hazard: beq resolves in the same cycle.
        branch_d = 1; rs_d = 5'd3; rt_d = 5'd4; eq_d = 1;
        step("nohaz", 1, 0, 0, 0, 1);
        clear_in();
        step("nohaz_after", 1, 0, 0, 0, 0);

        // ALU writer in EX: one stall, then bne resolves with MEM forwarding.
        do_reset("rst2");
        branch_d = 1; bne_d = 1; rs_d = 5'd3; rt_d = 5'd4; eq_d = 1;
        regwrite_e = 1; writereg_e = 5'd3;
        step("alu_ex_stall", 1, 1, 0, 0, 0);
        regwrite_e = 0; writereg_e = '0;
        regwrite_m = 1; writereg_m = 5'd3;
        step("alu_ex_resolve", 1, 0, 1, 0, 0);
        clear_in();
        step("alu_ex_after", 1, 0, 0, 0, 0);

        // Load in EX on rt plus ALU writer in MEM on rs: two stalls.
        do_reset("rst3");
        branch_d = 1; rs_d = 5'd3; rt_d = 5'd4; eq_d = 1;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 5'd4;
        regwrite_m = 1; writereg_m = 5'd3;
        step("load_ex_s0", 1, 1, 1, 0, 0);
        step("load_ex_s1", 1, 1, 1, 0, 0);
        step("load_ex_res", 1, 0, 1, 0, 1);
        clear_in();
        step("load_ex_after", 1, 0, 0, 0, 0);

        // Load in MEM on rs: one stall, no forwarding; beq not taken.
        do_reset("rst4");
        branch_d = 1; rs_d = 5'd5; rt_d = 5'd7; eq_d = 0;
        regwrite_m = 1; memtoreg_m = 1; writereg_m = 5'd5;
        step("load_mem_stall", 1, 1, 0, 0, 0);
        regwrite_m = 0; memtoreg_m = 0;
        step("load_mem_res", 1, 0, 0, 0, 0);

        // $0 destinations never match or forward.
        clear_in();
        branch_d = 1; rs_d = 5'd0; rt_d = 5'd0; eq_d = 1; bne_d = 1;
        regwrite_e = 1; writereg_e = 5'd0;
        regwrite_m = 1; writereg_m = 5'd0;
        step("zero_reg", 1, 0, 0, 0, 0);

        // MEM ALU result forwarded on rt only.
        clear_in();
        branch_d = 1; rs_d = 5'd9; rt_d = 5'd10; eq_d = 0; bne_d = 1;
        regwrite_m = 1; writereg_m = 5'd10;
        step("fwd_b", 1, 0, 0, 1, 1);

        // Branch withdrawn during STALL, then a new branch resolves from IDLE.
        do_reset("rst5");
        branch_d = 1; rs_d = 5'd6; rt_d = 5'd1; eq_d = 1;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 5'd6;
        step("wd_stall_s0", 1, 1, 0, 0, 0);
        branch_d = 0;
        step("wd_stall_drop", 1, 0, 0, 0, 0);
        clear_in();
        branch_d = 1; rs_d = 5'd6; rt_d = 5'd1; eq_d = 1;
        step("wd_stall_new", 1, 0, 0, 0, 1);

        // Branch withdrawn in RESOLVE: no pcsrc.
        clear_in();
        branch_d = 1; rs_d = 5'd2; rt_d = 5'd8; eq_d = 1;
        regwrite_e = 1; writereg_e = 5'd8;
        step("wd_res_s0", 1, 1, 0, 0, 0);
        clear_in();
        eq_d = 1;
        step("wd_res_drop", 1, 0, 0, 0, 0);

        // Reset while in STALL.
        do_reset("rst6");
        branch_d = 1; rs_d = 5'd4; rt_d = 5'd1; eq_d = 1;
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 5'd4;
        step("rmid_s0", 1, 1, 0, 0, 0);
        rst_n = 0;
        step("rmid_rst", 0, 1, 0, 0, 0);
        rst_n = 1;
        clear_in();
        eq_d = 1;
        step("rmid_after", 1, 0, 0, 0, 0);

        // Saturation: five taken branches with a 2-bit counter.
        do_reset("rst7");
        for (int i = 0; i < 5; i++) begin
            clear_in();
            branch_d = 1; rs_d = 5'd1; rt_d = 5'd2; eq_d = 1;
            step("sat_br", 1, 0, 0, 0, 1);
        end
        clear_in();
        step("sat_hold", 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Decode-stage branch resolution sequencer for the 5-stage MIPS pipeline. It watches the branch in ID and the writers in EX and MEM, and stalls the front end until both `equal_comparison` operands are valid. It then drives the comparator forwarding selects and produces the taken/flush decision for `beq`/`bne`. It also keeps saturating stall-cycle and taken-branch counters for performance debug.

## Interface
- `REG_W`, default 5: register-index width.
- `CNT_W`, default 16: width of each performance counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `branch_d`  in  1  a branch instruction is in ID.
- `bne_d`  in  1  1 = `bne`, 0 = `beq`; valid with `branch_d`.
- `rs_d`, `rt_d`  in  REG_W  source registers of the ID instruction.
- `regwrite_e`, `memtoreg_e`  in  1  EX-stage write enable and load flag.
- `writereg_e`  in  REG_W  EX-stage destination register.
- `regwrite_m`, `memtoreg_m`  in  1  MEM-stage write enable and load flag.
- `writereg_m`  in  REG_W  MEM-stage destination register.
- `eq_d`  in  1  `outb` from `equal_comparison`.
- `fwd_a_d`, `fwd_b_d`  out  1  select the MEM ALU result onto comparator `in0`/`in1`.
- `stall_f`, `stall_d`  out  1  hold the PC and the IF/ID register.
- `flush_e`  out  1  insert a bubble into ID/EX.
- `pcsrc_d`  out  1  branch taken; PC loads the branch target.
- `flush_d`  out  1  squash the IF/ID register on a taken branch.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.
- `taken_cnt`  out  CNT_W  saturating count of taken branches.

## Operation
- **Match rule.** A register matches when `writereg_x` is non-zero and equals `rs_d` or `rt_d`. `$0` never matches.
- **Hazard need.** The need `N` is the maximum of the following:
  - EX match with `memtoreg_e` = 1 gives `N` = 2.
  - EX match with `regwrite_e` = 1 and `memtoreg_e` = 0 gives `N` = 1.
  - MEM match with `memtoreg_m` = 1 gives `N` = 1.
  - Otherwise `N` = 0.
  - Simultaneous hazards on `rs` and `rt` take the maximum.
- **Forwarding.** `fwd_a_d` = `regwrite_m` & `memtoreg_m`=0 & `writereg_m`≠0 & `writereg_m`==`rs_d`. `fwd_b_d` is the same rule against `rt_d`. Both are combinational in every state.
- **States.**
  - **IDLE**
    - `branch_d` & `N`=0: resolve in the same cycle, stay in IDLE.
    - `branch_d` & `N`=1: assert stall, go to RESOLVE.
    - `branch_d` & `N`=2: assert stall, load `cnt`=1, go to STALL.
    - No branch: all control outputs are 0.
  - **STALL**: assert stall. Decrement `cnt`; at `cnt`=0 go to RESOLVE.
  - **RESOLVE**: no stall. The hazard check is skipped; the operands are valid by construction. Resolve the branch, then go to IDLE.
- **Stall.** `stall_f` = `stall_d` = `flush_e` = 1.
- **Resolve.** `pcsrc_d` = `eq_d` ^ `bne_d`, and `flush_d` = `pcsrc_d`.
- **Branch withdrawn.** If `branch_d` drops while in STALL or RESOLVE (for example an older flush), go to IDLE with no resolve and no further stall.
- **Counters.**
  - `stall_cnt` increments in every cycle with `stall_d` = 1.
  - `taken_cnt` increments in every cycle with `pcsrc_d` = 1.
  - Both saturate at 2^CNT_W−1; they do not wrap.

## Timing
- **Reset.** While `rst_n`=0 at a clock edge: state ← IDLE, `cnt` ← 0, both counters ← 0. Reset has priority over every other update.
- **Control outputs.** Mealy, combinational from state and inputs. While the block is held in reset they read as IDLE outputs.
- **Resolution latency, in cycles from the first cycle the branch is in ID to `pcsrc_d`:**
  - 0 for `N`=0.
  - 1 for `N`=1.
  - 2 for `N`=2.
- **Reset mid-operation.** Reset in STALL or RESOLVE returns to IDLE on that edge and no `pcsrc_d` is issued.
- **Stall length.** Exactly `N` consecutive stall cycles per branch, never more.

## Structure
- Package `mips_hazard_pkg`:
  - State enum `br_state_t` {IDLE, STALL, RESOLVE}.
  - Constant `ZERO_REG`.
  - Function `hazard_need()` returning a 2-bit `N`.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `count`), instantiated twice for the performance counters.

## Test plan
- **No hazard:** `beq`, `rs`=3, `rt`=4, `regwrite_e`=0, `eq_d`=1 → same cycle `pcsrc_d`=1, `flush_d`=1, no stall, `taken_cnt`=1.
- **ALU in EX:** `writereg_e`=3, `regwrite_e`=1 → one cycle with stall/flush_e. Next cycle drive `writereg_m`=3 → `fwd_a_d`=1, and `bne` with `eq_d`=1 gives `pcsrc_d`=0. `stall_cnt`=1.
- **Load in EX on `rt`**, plus an ALU writer in MEM on `rs` → exactly 2 stall cycles, then resolve. `stall_cnt`=2.
- **`$0` destination:** `writereg_e`=0, `rs_d`=0, `regwrite_e`=1 → no stall, `fwd_a_d`=0.
- **Reset mid-operation:** `rst_n`=0 during STALL → next cycle IDLE, outputs 0, both counters 0, no `pcsrc_d`.
- **Saturation:** `CNT_W`=2, 5 taken branches → `taken_cnt` holds at 3.
